// File: rtl/lsu_stage_if.sv
// Memory bus between the load/store stage (master) and the data memory (slave).
// Request fields are held stable by the master until bus_ack.
interface lsu_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage: passes ALU results through, runs one bus transaction per
// aligned memory op (IDLE/REQ), and produces a registered writeback pulse.
module lsu_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] exec_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        stall,
    lsu_stage_if.master bus,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        misaligned
);

    typedef enum logic {IDLE, REQ} state_t;

    typedef struct packed {
        logic [1:0] off;
        logic [1:0] size;
        logic       uns;
        logic       we;
        logic [4:0] rd;
        logic       rw;
    } lsu_req_t;

    state_t      state;
    lsu_req_t    lat;
    logic        is_mem, is_half, is_word, mis, start;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] sh;
    logic [31:0] ldata;

    assign is_mem  = mem_rd | mem_wr;
    assign is_half = (funct3[1:0] == 2'b01);
    assign is_word = funct3[1];
    assign mis     = (is_half & exec_result[0]) | (is_word & (|exec_result[1:0]));
    assign start   = (state == IDLE) && valid_in && is_mem && !mis;

    // Reset wins: no stall while rst is asserted, even mid-transaction.
    assign stall = !rst && (start || ((state == REQ) && !bus.bus_ack));

    for (genvar l = 0; l < 4; l++) begin : g_lane
        assign be_n[l] = is_word | (is_half ? (exec_result[1] == 1'(l / 2))
                                            : (exec_result[1:0] == 2'(l)));
        assign wdata_n[8*l +: 8] = is_word ? store_data[8*l +: 8] :
                                   is_half ? store_data[8*(l % 2) +: 8] :
                                             store_data[7:0];
    end

    // Shift the addressed lane down to bit 0, then extend by size/sign.
    always_comb begin
        sh = bus.bus_rdata >> {lat.off, 3'b000};
        case (lat.size)
            2'b00:   ldata = lat.uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   ldata = lat.uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: ldata = bus.bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            lat           <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_data       <= '0;
            wb_rd         <= '0;
            misaligned    <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (!is_mem) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= exec_result;
                            wb_rd        <= rd_in;
                            wb_reg_write <= reg_write_in;
                        end else if (mis) begin
                            wb_valid     <= 1'b1;
                            misaligned   <= 1'b1;
                            wb_data      <= exec_result;
                            wb_rd        <= rd_in;
                            wb_reg_write <= 1'b0;
                        end else begin
                            state         <= REQ;
                            lat           <= '{off: exec_result[1:0], size: funct3[1:0],
                                               uns: funct3[2], we: mem_wr,
                                               rd: rd_in, rw: reg_write_in};
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= mem_wr;
                            bus.bus_addr  <= {exec_result[31:2], 2'b00};
                            bus.bus_wdata <= wdata_n;
                            bus.bus_be    <= be_n;
                        end
                    end
                end
                REQ: begin
                    // Upstream still presents the accepted op here; it is not re-taken.
                    if (bus.bus_ack) begin
                        state        <= IDLE;
                        bus.bus_req  <= 1'b0;
                        bus.bus_we   <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_rd        <= lat.rd;
                        wb_reg_write <= !lat.we && lat.rw;
                        if (!lat.we) wb_data <= ldata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Randomized bench for lsu_stage with a transaction-level reference model and
// a writeback scoreboard that checks both values and cycle of arrival.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_rd, mem_wr, reg_write_in;
    logic [2:0]  funct3;
    logic [31:0] exec_result, store_data;
    logic [4:0]  rd_in;
    logic        stall, wb_valid, wb_reg_write, misaligned;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    lsu_stage_if bus_if();

    lsu_stage dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .funct3(funct3), .exec_result(exec_result), .store_data(store_data),
        .rd_in(rd_in), .reg_write_in(reg_write_in), .stall(stall), .bus(bus_if),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .wb_rd(wb_rd), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        logic        chkd;
    } wb_exp_t;

    wb_exp_t     wbq[$];
    wb_exp_t     e;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_wb_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1]) return 4'hF;
        if (f3[0]) return 4'b0011 << (2 * a[1]);
        return 4'b0001 << a[1:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1]) return d;
        if (f3[0]) return {2{d[15:0]}};
        return {4{d[7:0]}};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] r);
        int          n = 8 * a[1:0];
        logic [31:0] s = r >> n;
        if (f3[1]) return r;
        if (f3[0]) return f3[2] ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
        return f3[2] ? {24'b0, s[7:0]} : {{24{s[7]}}, s[7:0]};
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a);
        return (f3[1] && a[1:0] != 2'b00) || (f3[1:0] == 2'b01 && a[0]);
    endfunction

    // Writeback scoreboard: every pulse must match the head entry on its due cycle.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (wbq.size() == 0 || wbq[0].due != cyc) begin
                chk("wb_spurious", 32'(wb_valid), 32'd0);
            end else begin
                e = wbq.pop_front();
                chk("wb_mis", 32'(misaligned), 32'(e.mis));
                chk("wb_rw", 32'(wb_reg_write), 32'(e.rw));
                if (!e.mis) chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                if (e.chkd) chk("wb_data", wb_data, e.data);
                last_wb_data = wb_data;
            end
        end else begin
            chk("mis_nowb", 32'(misaligned), 32'd0);
            if (wbq.size() != 0 && wbq[0].due == cyc) begin
                chk("wb_late", 32'(wb_valid), 32'd1);
                void'(wbq.pop_front());
            end
        end
    end

    task automatic do_idle();
        valid_in = 1'b0; mem_rd = $urandom; mem_wr = $urandom; funct3 = 3'($urandom);
        exec_result = $urandom; store_data = $urandom; rd_in = 5'($urandom);
        reg_write_in = $urandom; bus_if.bus_ack = $urandom; bus_if.bus_rdata = $urandom;
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_req", 32'(bus_if.bus_req), 32'd0);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
    endtask

    task automatic do_op(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rw, input int dly, input logic [31:0] rdata);
        logic    mem, mis;
        wb_exp_t x;
        mem = r | w;
        mis = mem && ref_mis(f3, a);
        valid_in = 1'b1; mem_rd = r; mem_wr = w; funct3 = f3; exec_result = a;
        store_data = sd; rd_in = rd; reg_write_in = rw;
        bus_if.bus_ack = $urandom;
        bus_if.bus_rdata = $urandom;
        @(negedge clk);
        chk("acc_stall", 32'(stall), 32'(mem && !mis));
        chk("acc_req", 32'(bus_if.bus_req), 32'd0);
        x.due = cyc + 1; x.rd = rd; x.mis = mis;
        if (!mem || mis) begin
            x.data = a; x.rw = mis ? 1'b0 : rw; x.chkd = !mis;
            if (mis) x.due = cyc + 1;
            wbq.push_back(x);
            @(posedge clk); #1;
            bus_if.bus_ack = 1'b0;
            return;
        end
        for (int k = 0; k <= dly; k++) begin
            @(posedge clk); #1;
            bus_if.bus_ack = (k == dly);
            bus_if.bus_rdata = (k == dly) ? rdata : $urandom;
            @(negedge clk);
            chk("req_req", 32'(bus_if.bus_req), 32'd1);
            chk("req_we", 32'(bus_if.bus_we), 32'(w));
            chk("req_addr", bus_if.bus_addr, {a[31:2], 2'b00});
            chk("req_stall", 32'(stall), 32'(k != dly));
            if (w) begin
                chk("req_be", 32'(bus_if.bus_be), 32'(ref_be(f3, a)));
                chk("req_wdata", bus_if.bus_wdata, ref_wdata(f3, sd));
            end
        end
        x.due = cyc + 1; x.rw = !w && rw; x.chkd = !w;
        x.data = ref_load(f3, a, rdata);
        wbq.push_back(x);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = '0;
        exec_result = '0; store_data = '0; rd_in = '0; reg_write_in = 1'b0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        valid_in = 1'b1; mem_rd = 1'b1; funct3 = 3'b010; exec_result = 32'h100;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst_we", 32'(bus_if.bus_we), 32'd0);
        chk("rst_addr", bus_if.bus_addr, 32'd0);
        chk("rst_wdata", bus_if.bus_wdata, 32'd0);
        chk("rst_be", 32'(bus_if.bus_be), 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_wbrw", 32'(wb_reg_write), 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_wbrd", 32'(wb_rd), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_idle();

        // LB with ack after three waiting REQ cycles
        do_op(1, 0, 3'b000, 32'h1003, 32'h0, 5'd3, 1, 3, 32'h8000_0000);
        do_idle();
        chk("lb_data", last_wb_data, 32'hFFFF_FF80);
        // LHU, immediate ack
        do_op(1, 0, 3'b101, 32'h2002, 32'h0, 5'd4, 1, 0, 32'hBEEF_1234);
        do_idle();
        chk("lhu_data", last_wb_data, 32'h0000_BEEF);
        // SB to byte lane 3
        do_op(0, 1, 3'b000, 32'h13, 32'hAABB_CCDD, 5'd5, 1, 1, 32'h0);
        do_idle();
        // misaligned LW
        do_op(1, 0, 3'b010, 32'h6, 32'h0, 5'd6, 1, 0, 32'h0);
        do_idle();
        // ADD result then SW back-to-back
        do_op(0, 0, 3'b000, 32'h55, 32'h0, 5'd7, 1, 0, 32'h0);
        do_op(0, 1, 3'b010, 32'h40, 32'h1234_5678, 5'd8, 0, 0, 32'h0);
        do_idle();
        chk("add_data", last_wb_data == 32'h55 ? 32'h55 : last_wb_data, 32'h55);

        // Reset during REQ, then a late ack
        valid_in = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010;
        exec_result = 32'h300; rd_in = 5'd9; reg_write_in = 1'b1;
        @(negedge clk);
        chk("mr_acc_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mr_rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; valid_in = 1'b0; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mr_req", 32'(bus_if.bus_req), 32'd0);
        chk("mr_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        do_idle();

        // Randomized mix of ALU ops, loads, stores and idle gaps
        for (int i = 0; i < 300; i++) begin
            int          kind = $urandom_range(0, 9);
            logic [31:0] a = $urandom;
            if (kind < 2) begin
                do_idle();
            end else if (kind < 5) begin
                do_op(0, 0, 3'($urandom), a, $urandom, 5'($urandom), $urandom, 0, 32'h0);
            end else begin
                do_op(kind < 7 || kind == 9, kind >= 7, 3'($urandom), a, $urandom,
                      5'($urandom), $urandom, $urandom_range(0, 3), $urandom);
            end
        end
        do_idle();
        do_idle();
        chk("drain", 32'(wbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 The block SHALL run on a single clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 valid_in  in  1  execute-stage result valid this cycle.
REQ-005 mem_rd  in  1  load.
REQ-006 mem_wr  in  1  store; takes priority if mem_rd is also set.
REQ-007 funct3  in  3  access size and sign:
- [1:0]: 00 byte, 01 half, 1x word.
- [2]: 1 zero-extend.
REQ-008 exec_result  in  32  effective address, or ALU result for non-memory ops.
REQ-009 store_data  in  32  rs2 value.
REQ-010 rd_in  in  5  destination register.
REQ-011 reg_write_in  in  1  writeback enable.
REQ-012 stall  out  1  upstream holds its inputs while high.
REQ-013 bus_req, bus_we  out  1 each  request and write strobe.
REQ-014 bus_addr  out  32  word-aligned address, exec_result with [1:0] forced to 00.
REQ-015 bus_wdata  out  32; bus_be  out  4  byte enables.
REQ-016 bus_ack  in  1; bus_rdata  in  32  completion and read data, valid with bus_ack.
REQ-017 wb_valid, wb_reg_write  out  1 each; wb_data  out  32; wb_rd  out  5  registered writeback outputs.
REQ-018 misaligned  out  1  one-cycle fault pulse, aligned with wb_valid.

Function
REQ-019 The FSM SHALL have two states: IDLE and REQ.
REQ-020 IDLE, valid_in=0: the block SHALL update no outputs, and wb_valid SHALL be 0 next cycle.
REQ-021 IDLE, valid_in=1, no memory op: next cycle wb_valid=1, wb_data=exec_result, wb_rd=rd_in, wb_reg_write=reg_write_in; stall=0.
REQ-022 Misalignment SHALL be defined as half with addr[0]=1, or word with addr[1:0]≠00.
REQ-023 IDLE, misaligned memory op: no bus request; next cycle wb_valid=1, misaligned=1, wb_reg_write=0; stall=0.
REQ-024 IDLE, aligned memory op:
- stall=1 combinationally.
- Latch address, data, size, rd and direction.
- Enter REQ.
REQ-025 REQ: bus_req=1, with bus_addr, bus_we, bus_wdata and bus_be held stable from registers until bus_ack.
REQ-026 Stall in REQ SHALL be stall = !bus_ack; the held upstream instruction SHALL NOT be re-accepted on the ack cycle.
REQ-027 On bus_ack in REQ, the FSM SHALL return to IDLE and assert wb_valid on the next cycle.
REQ-028 Minimum memory-op latency SHALL be 2 cycles from acceptance to wb_valid, when ack arrives in the first REQ cycle.
REQ-029 Store byte enables and write data:
- SB: be=0001<<addr[1:0], wdata={4{data[7:0]}}.
- SH: be=0011<<(2*addr[1]), wdata={2{data[15:0]}}.
- SW: be=1111, wdata=data.
REQ-030 Load extraction: select the byte/half lane of bus_rdata by latched addr[1:0], then sign-extend, or zero-extend when funct3[2]=1; word loads pass through unchanged.
REQ-031 On a store, wb_valid=1 and wb_reg_write=0.
REQ-032 wb_valid and misaligned SHALL be single-cycle pulses.
REQ-033 bus_ack outside REQ SHALL be ignored.

Reset
REQ-034 rst SHALL force IDLE, with stall, bus_req, bus_we, wb_valid, wb_reg_write and misaligned all 0, and bus_be, bus_addr, bus_wdata, wb_data and wb_rd all zero.
REQ-035 rst in REQ SHALL abandon the transaction; a late bus_ack after reset SHALL be ignored.
REQ-036 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-037 Load with delayed ack: LB, addr=0x1003, ack after 3 REQ cycles, bus_rdata=0x80_00_00_00 -> stall for 4 cycles, bus_addr=0x1000, wb_data=0xFFFFFF80, wb_valid one cycle after ack.
REQ-038 Unsigned half load: LHU, addr=0x2002, ack in first REQ cycle, bus_rdata=0xBEEF1234 -> wb_data=0x0000BEEF, latency 2 cycles.
REQ-039 Store: SB, addr=0x13, store_data=0xAABBCCDD -> bus_be=1000, bus_wdata=0xDDDDDDDD, bus_we=1, then wb_valid=1 with wb_reg_write=0.
REQ-040 Misaligned load: LW, addr=0x6 -> no bus_req, stall=0, next cycle misaligned=1, wb_valid=1, wb_reg_write=0.
REQ-041 Back-to-back: ADD result 0x55 followed by SW, ack immediate -> wb 0x55 next cycle, SW completes with no duplicate bus request.
REQ-042 Reset mid-transaction: rst asserted during REQ, then bus_ack pulsed -> bus_req=0 the cycle after rst, no wb_valid, state IDLE.
